grf_scoreboard: RTL and testbench

GRF_SCOREBOARD -- requirements
Module: grf_scoreboard

---
 rtl/grf_scoreboard.sv | 73 +++++++
 tb/tb_grf_scoreboard.sv | 119 +++++++++++
 2 files changed

// File: rtl/grf_scoreboard.sv
// grf_scoreboard: GPR write-in-flight scoreboard with per-register latency countdown and stall generation.
// Optional MDU busy tracking is enabled by defining SB_MDU_EN.
module grf_scoreboard #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        issue_valid,
    input  logic [4:0]  issue_rs,
    input  logic        issue_rs_use,
    input  logic [4:0]  issue_rt,
    input  logic        issue_rt_use,
    input  logic        issue_wr_en,
    input  logic [4:0]  issue_wr_addr,
    input  logic [2:0]  issue_lat,
    input  logic        issue_md_use,
    input  logic        issue_md_start,
    input  logic        issue_md_div,
    input  logic        retire_valid,
    input  logic [4:0]  retire_addr,
    output logic        stall,
    output logic [31:0] pending,
    output logic        md_busy
);
    logic [31:0] pend;
    logic [2:0]  cnt [32];
    logic        md_stall;
    logic        accept;
    assign accept  = issue_valid && !stall;
    assign pending = {pend[31:1], 1'b0};
    assign stall   = issue_valid && ((issue_rs_use && cnt[issue_rs] != 3'd0) ||
                                     (issue_rt_use && cnt[issue_rt] != 3'd0) || md_stall);
    // Register 0 is never loaded, so its cnt/pend stay at their reset value of 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            pend <= '0;
            for (int r = 0; r < 32; r++) cnt[r] <= 3'd0;
        end else begin
            for (int r = 1; r < 32; r++) begin
                if (accept && issue_wr_en && issue_wr_addr == 5'(r)) begin
                    pend[r] <= 1'b1;
                    cnt[r]  <= issue_lat;
                end else if (retire_valid && retire_addr == 5'(r)) begin
                    pend[r] <= 1'b0;
                    cnt[r]  <= 3'd0;
                end else if (cnt[r] != 3'd0) begin
                    cnt[r]  <= cnt[r] - 3'd1;
                end
            end
        end
    end
`ifdef SB_MDU_EN
    localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int MW   = $clog2(MAXC + 1);
    logic [MW-1:0] md_cnt;
    assign md_busy  = md_cnt != '0;
    assign md_stall = issue_md_use && md_busy;
    always_ff @(posedge clk) begin
        if (reset)
            md_cnt <= '0;
        else if (accept && issue_md_start)
            md_cnt <= issue_md_div ? MW'(DIV_CYCLES) : MW'(MULT_CYCLES);
        else if (md_busy)
            md_cnt <= md_cnt - MW'(1);
    end
`else
    logic unused_md;
    assign unused_md = ^{issue_md_use, issue_md_start, issue_md_div};
    assign md_busy   = 1'b0;
    assign md_stall  = 1'b0;
`endif
endmodule

// File: tb/tb_grf_scoreboard.sv
// tb_grf_scoreboard: directed and random checks of grf_scoreboard against a ready-time reference model.
module tb_grf_scoreboard;
    logic        clk = 1'b0, reset = 1'b0;
    logic        issue_valid = 0, issue_rs_use = 0, issue_rt_use = 0, issue_wr_en = 0;
    logic [4:0]  issue_rs = 0, issue_rt = 0, issue_wr_addr = 0, retire_addr = 0;
    logic [2:0]  issue_lat = 0;
    logic        issue_md_use = 0, issue_md_start = 0, issue_md_div = 0, retire_valid = 0;
    logic        stall, md_busy;
    logic [31:0] pending;
`ifdef SB_MDU_EN
    localparam bit MDU = 1'b1;
`else
    localparam bit MDU = 1'b0;
`endif
    int checks = 0, errors = 0, edges = 0;
    bit mpend [32];
    int ready_at [32];
    int md_free = 0;

    grf_scoreboard #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk(clk), .reset(reset), .issue_valid(issue_valid), .issue_rs(issue_rs),
        .issue_rs_use(issue_rs_use), .issue_rt(issue_rt), .issue_rt_use(issue_rt_use),
        .issue_wr_en(issue_wr_en), .issue_wr_addr(issue_wr_addr), .issue_lat(issue_lat),
        .issue_md_use(issue_md_use), .issue_md_start(issue_md_start), .issue_md_div(issue_md_div),
        .retire_valid(retire_valid), .retire_addr(retire_addr),
        .stall(stall), .pending(pending), .md_busy(md_busy));

    always #5 clk = ~clk;

    // A register's result is forwardable once the edge count reaches its ready time.
    function automatic bit model_stall();
        return issue_valid && ((issue_rs_use && issue_rs != 0 && ready_at[issue_rs] > edges) ||
                               (issue_rt_use && issue_rt != 0 && ready_at[issue_rt] > edges) ||
                               (MDU && issue_md_use && md_free > edges));
    endfunction

    task automatic cyc(input logic v, input int rs, input logic rsu, input int rt, input logic rtu,
                       input logic we, input int wa, input int lat, input logic mu, input logic ms,
                       input logic md, input logic rv, input int ra, input logic rst);
        bit exp_stall;
        logic [31:0] exp_pend;
        @(negedge clk);
        issue_valid = v; issue_rs = 5'(rs); issue_rs_use = rsu; issue_rt = 5'(rt); issue_rt_use = rtu;
        issue_wr_en = we; issue_wr_addr = 5'(wa); issue_lat = 3'(lat);
        issue_md_use = mu; issue_md_start = ms; issue_md_div = md;
        retire_valid = rv; retire_addr = 5'(ra); reset = rst;
        #1;
        exp_stall = model_stall();
        checks++;
        assert (stall === exp_stall) else begin
            errors++;
            $error("FAIL stall t=%0t got %b exp %b", $time, stall, exp_stall);
        end
        @(posedge clk);
        edges++;
        if (rst) begin
            for (int r = 0; r < 32; r++) begin mpend[r] = 0; ready_at[r] = 0; end
            md_free = 0;
        end else begin
            if (rv && ra != 0) begin mpend[ra] = 0; ready_at[ra] = 0; end
            if (v && !exp_stall && we && wa != 0) begin mpend[wa] = 1; ready_at[wa] = edges + lat; end
            if (MDU && v && !exp_stall && ms) md_free = edges + (md ? 10 : 5);
        end
        #1;
        exp_pend = '0;
        for (int r = 1; r < 32; r++) exp_pend[r] = mpend[r];
        checks++;
        assert (pending === exp_pend) else begin
            errors++;
            $error("FAIL pending t=%0t got %h exp %h", $time, pending, exp_pend);
        end
        checks++;
        assert (md_busy === (md_free > edges)) else begin
            errors++;
            $error("FAIL md_busy t=%0t got %b exp %b", $time, md_busy, md_free > edges);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0,0,0,0,0,0,0,0,0,0,0,0,0,0);
    endtask

    initial begin
        cyc(0,0,0,0,0,0,0,0,0,0,0,0,0,1);
        idle(1);
        // wr $5 lat 2, then dependent read held until accepted
        cyc(1,0,0,0,0,1,5,2,0,0,0,0,0,0);
        for (int i = 0; i < 3; i++) cyc(1,5,1,0,0,0,0,0,0,0,0,0,0,0);
        // lat 0 forwards immediately; retire clears pending
        cyc(1,0,0,0,0,1,8,0,0,0,0,0,0,0);
        cyc(1,0,0,8,1,0,0,0,0,0,0,0,0,0);
        cyc(0,0,0,0,0,0,0,0,0,0,0,1,8,0);
        idle(1);
        // register 0 never tracked
        cyc(1,0,0,0,0,1,0,3,0,0,0,0,0,0);
        cyc(1,0,1,0,1,0,0,0,0,0,0,0,0,0);
        // retire and issue to $9 in the same cycle: issue wins
        cyc(1,0,0,0,0,1,9,3,0,0,0,0,0,0);
        cyc(1,0,0,0,0,1,9,1,0,0,0,1,9,0);
        for (int i = 0; i < 2; i++) cyc(1,9,1,0,0,0,0,0,0,0,0,0,0,0);
        // divide then mflo, with an independent addu interleaved
        cyc(1,0,0,0,0,0,0,0,1,1,1,0,0,0);
        cyc(1,1,1,2,1,1,4,0,0,0,0,0,0,0);
        for (int i = 0; i < 11; i++) cyc(1,0,0,0,0,1,6,0,1,0,0,0,0,0);
        cyc(1,0,0,0,0,0,0,0,1,1,0,0,0,0);
        // reset mid-countdown abandons in-flight state
        cyc(1,0,0,0,0,1,3,4,0,0,0,0,0,0);
        cyc(0,0,0,0,0,0,0,0,0,0,0,0,0,1);
        cyc(1,3,1,3,1,0,0,0,1,0,0,0,0,0);
        for (int i = 0; i < 600; i++)
            cyc($urandom_range(0,9) < 7, $urandom_range(0,7), $urandom_range(0,1),
                $urandom_range(0,7), $urandom_range(0,1), $urandom_range(0,1),
                $urandom_range(0,7), $urandom_range(0,7), $urandom_range(0,3) == 0,
                $urandom_range(0,7) == 0, $urandom_range(0,1), $urandom_range(0,3) == 0,
                $urandom_range(0,7), $urandom_range(0,59) == 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
